// File: rtl/ws2812_frame_sequencer.sv
// Pixel frame store and command source feeding a WS2812 controller.
// Streams a frame of pixels from RAM as TX answers, then one RESET (latch) answer.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no frame; answers IDLE, waits for a pending start
//  ST_TX    | presenting pixel[idx] with command TX
//  ST_END   | last pixel consumed; answers IDLE so controller enters init
//  ST_LATCH | answers RESET; consumption ends the frame
module ws2812_frame_sequencer #(
    parameter int MAX_PIXELS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [ADDR_W:0]   num_pixels,
    input  logic              start,
    input  logic              cmd_request,
    input  logic              data_request,
    output logic [1:0]        command,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TX    = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_TX    = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PIXELS);

    logic [23:0] pixel_mem [MAX_PIXELS];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             start_pending_q, start_pending_d;
    logic             req_d_q;

    logic             req;
    logic             start_valid;
    logic             launch;
    logic [CNT_W-1:0] idx_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]      rd_data;

    assign req         = cmd_request | data_request;
    assign start_valid = start && (num_pixels != '0) && (num_pixels <= MAX_LEN);
    assign idx_next    = idx_q + 1'b1;

    // Launch waits for a quiet request pipeline and skips the frame_done
    // cycle, so a back-to-back frame never presents TX right after the latch.
    assign launch = (state_q == ST_IDLE) && start_pending_q && !req && !req_d_q
                    && !frame_done_q;

    // Asynchronous read lets the next pixel be fetched and registered in the
    // same edge that retires the current answer.
    assign rd_addr = launch ? '0 : idx_next[ADDR_W-1:0];
    assign rd_data = pixel_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pixel_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        len_d           = len_q;
        cmd_d           = cmd_q;
        rgb_d           = rgb_q;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        start_pending_d = start_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    len_d           = num_pixels;
                    idx_d           = '0;
                    rgb_d           = rd_data;
                    cmd_d           = CMD_TX;
                    busy_d          = 1'b1;
                    start_pending_d = 1'b0;
                    state_d         = ST_TX;
                end
            end
            ST_TX: begin
                if (req_d_q) begin
                    if (idx_next < len_q) begin
                        idx_d = idx_next;
                        rgb_d = rd_data;
                    end else begin
                        cmd_d   = CMD_IDLE;
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (req_d_q) begin
                    cmd_d   = CMD_RESET;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (req_d_q) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    cmd_d        = CMD_IDLE;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A start seen in the launch cycle is a new request and stays pending.
        if (start_valid) begin
            start_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            len_q           <= '0;
            cmd_q           <= CMD_IDLE;
            rgb_q           <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            start_pending_q <= 1'b0;
            req_d_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            len_q           <= len_d;
            cmd_q           <= cmd_d;
            rgb_q           <= rgb_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            start_pending_q <= start_pending_d;
            req_d_q         <= req;
        end
    end

    assign command    = cmd_q;
    assign r          = rgb_q[23:16];
    assign g          = rgb_q[15:8];
    assign b          = rgb_q[7:0];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: answer-queue model checked every cycle,
// plus directed handshakes with literal expected answers.
module tb_ws2812_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [6:0]  num_pixels = '0;
    logic        start = 1'b0;
    logic        cmd_request = 1'b0;
    logic        data_request = 1'b0;
    logic [1:0]  command;
    logic [7:0]  r, g, b;
    logic        busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    ws2812_frame_sequencer #(.MAX_PIXELS(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_pixels(num_pixels), .start(start), .cmd_request(cmd_request),
        .data_request(data_request), .command(command), .r(r), .g(g), .b(b),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: a frame is a queue of answers; front is what is presented now.
    // Entry >= 0 is TX of that pixel, -1 is the IDLE answer, -2 is RESET.
    logic [23:0] shadow [64];
    int          m_q[$];
    logic [1:0]  m_cmd = 2'b00;
    logic [23:0] m_rgb = '0;
    logic        m_busy = 1'b0, m_fd = 1'b0, m_pend = 1'b0, m_reqd = 1'b0;
    logic        m_fd_now, m_req_now;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cmd = 2'b00; m_rgb = '0; m_busy = 1'b0; m_fd = 1'b0;
            m_pend = 1'b0; m_reqd = 1'b0; m_q.delete();
        end else begin
            m_fd_now  = m_fd;
            m_fd      = 1'b0;
            m_req_now = cmd_request | data_request;
            if (m_busy && m_reqd) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 1'b0; m_fd = 1'b1; m_cmd = 2'b00;
                end else if (m_q[0] >= 0) begin
                    m_cmd = 2'b01; m_rgb = shadow[m_q[0]];
                end else begin
                    m_cmd = (m_q[0] == -2) ? 2'b10 : 2'b00;
                end
            end else if (!m_busy && m_pend && !m_req_now && !m_reqd && !m_fd_now) begin
                m_q.delete();
                for (int i = 0; i < int'(num_pixels); i++) m_q.push_back(i);
                m_q.push_back(-1);
                m_q.push_back(-2);
                m_cmd = 2'b01; m_rgb = shadow[0]; m_busy = 1'b1; m_pend = 1'b0;
            end
            if (start && num_pixels >= 1 && num_pixels <= 64) m_pend = 1'b1;
            m_reqd = m_req_now;
        end
        if (wr_en) shadow[wr_addr] = wr_data;
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            tests++;
            if ({command, r, g, b, busy, frame_done} !== {m_cmd, m_rgb, m_busy, m_fd}) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t got cmd=%b rgb=%h busy=%b fd=%b want cmd=%b rgb=%h busy=%b fd=%b",
                         $time, command, {r, g, b}, busy, frame_done, m_cmd, m_rgb, m_busy, m_fd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [23:0] px_pat(input int i);
        logic [7:0] v;
        v = 8'(i);
        case (i)
            0: px_pat = 24'hFF0000;
            1: px_pat = 24'h00FF00;
            2: px_pat = 24'h0000FF;
            default: px_pat = {v, ~v, v ^ 8'h5A};
        endcase
    endfunction

    // All tasks are entered and left at a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_px(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input int n);
        num_pixels = 7'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(3);
    endtask

    // kind: 0 cmd_request, 1 data_request, 2 both
    task automatic consume(input int kind, output logic [1:0] c, output logic [23:0] px);
        c = command;
        cmd_request  = (kind != 1);
        data_request = (kind != 0);
        @(negedge clk);
        px = {r, g, b};
        cmd_request = 1'b0; data_request = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame_tail(input string tag);
        logic [1:0] c; logic [23:0] px;
        consume(1, c, px);
        check({tag, "_end_cmd"}, 32'(c), 32'h0);
        consume(0, c, px);
        check({tag, "_latch_cmd"}, 32'(c), 32'h2);
        check({tag, "_fd_pulse"}, 32'(frame_done), 32'h1);
        tick(1);
        check({tag, "_fd_clear"}, 32'(frame_done), 32'h0);
        check({tag, "_busy_clear"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  c;
        logic [23:0] px;
        int          gap;

        tick(2);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        check("reset_cmd", 32'(command), 32'h0);
        check("reset_rgb", 32'({r, g, b}), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_fd", 32'(frame_done), 32'h0);

        for (int i = 0; i < 64; i++) write_px(i, px_pat(i));

        // basic three-pixel frame
        start_frame(3);
        check("f1_busy", 32'(busy), 32'h1);
        consume(1, c, px); check("f1_tx0_cmd", 32'(c), 32'h1); check("f1_tx0_px", 32'(px), 32'hFF0000);
        consume(2, c, px); check("f1_tx1_cmd", 32'(c), 32'h1); check("f1_tx1_px", 32'(px), 32'h00FF00);
        consume(1, c, px); check("f1_tx2_cmd", 32'(c), 32'h1); check("f1_tx2_px", 32'(px), 32'h0000FF);
        frame_tail("f1");

        // idle polling does nothing
        for (int i = 0; i < 10; i++) begin
            consume(0, c, px);
            check("idle_poll_cmd", 32'(c), 32'h0);
        end
        check("idle_poll_busy", 32'(busy), 32'h0);

        // out-of-range lengths are ignored
        start_frame(0);
        tick(2);
        check("len0_busy", 32'(busy), 32'h0);
        check("len0_cmd", 32'(command), 32'h0);
        start_frame(65);
        tick(2);
        check("len65_busy", 32'(busy), 32'h0);
        check("len65_cmd", 32'(command), 32'h0);

        // full-depth frame
        start_frame(64);
        for (int i = 0; i < 64; i++) begin
            consume(1, c, px);
            check("f64_tx_cmd", 32'(c), 32'h1);
            check("f64_tx_px", 32'(px), 32'(px_pat(i)));
        end
        frame_tail("f64");

        // start while busy launches a second frame after the latch
        start_frame(2);
        consume(1, c, px); check("mid_tx0_px", 32'(px), 32'hFF0000);
        start = 1'b1; @(negedge clk); start = 1'b0;
        consume(1, c, px); check("mid_tx1_px", 32'(px), 32'h00FF00);
        consume(1, c, px); check("mid_end_cmd", 32'(c), 32'h0);
        consume(0, c, px); check("mid_latch_cmd", 32'(c), 32'h2);
        check("mid_fd_pulse", 32'(frame_done), 32'h1);
        gap = 0;
        while (command != 2'b01 && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("mid_relaunch_gap_ok", 32'(gap >= 2 && gap < 10), 32'h1);
        consume(1, c, px); check("mid2_tx0_px", 32'(px), 32'hFF0000);
        consume(1, c, px); check("mid2_tx1_px", 32'(px), 32'h00FF00);
        frame_tail("mid2");

        // writes during a frame
        start_frame(3);
        write_px(1, 24'h123456);
        consume(1, c, px); check("wr_tx0_px", 32'(px), 32'hFF0000);
        write_px(0, 24'hABCDEF);
        consume(1, c, px); check("wr_tx1_px", 32'(px), 32'h123456);
        consume(1, c, px); check("wr_tx2_px", 32'(px), 32'h0000FF);
        frame_tail("wr");

        // reset mid-frame
        start_frame(3);
        consume(1, c, px); check("rst_tx0_px", 32'(px), 32'hABCDEF);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("rst_mid_cmd", 32'(command), 32'h0);
        check("rst_mid_rgb", 32'({r, g, b}), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        tick(6);
        check("rst_mid_no_fd", 32'(frame_done), 32'h0);
        start_frame(3);
        consume(1, c, px); check("post_rst_tx0", 32'(px), 32'hABCDEF);
        consume(1, c, px); check("post_rst_tx1", 32'(px), 32'h123456);
        consume(1, c, px); check("post_rst_tx2", 32'(px), 32'h0000FF);
        frame_tail("post_rst");

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
